shrink_queue: RTL and testbench



---
 rtl/stream_pkg.sv | 23 ++
 rtl/shrink_queue.sv | 117 +++++++++++
 tb/tb_shrink_queue.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// Shared overlay stream package: serializer state encoding and the
// width-ratio helper used to size wide-to-narrow converters.
package stream_pkg;

    // Serializer state: the holding register is either empty or draining.
    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Narrow words per wide word. Returns 0 when the widths do not divide
    // evenly, so callers can reject the pairing at elaboration.
    function automatic int calc_ratio(input int in_w, input int out_w);
        if (out_w <= 0) begin
            return 0;
        end
        if ((in_w % out_w) != 0) begin
            return 0;
        end
        return in_w / out_w;
    endfunction

endpackage

// File: rtl/shrink_queue.sv
// Width-reducing stream serializer. Takes one IN_WIDTH word per upstream
// handshake and emits it as MAX OUT_WIDTH words, least-significant slice
// first, with a zero-bubble reload when the last slice leaves.
module shrink_queue
    import stream_pkg::*;
#(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IN_WIDTH-1:0]  din,
    input  logic                 vld_in,
    output logic                 rdy_upward,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 vld_out,
    input  logic                 rdy_downward
);

    localparam int MAX   = calc_ratio(IN_WIDTH, OUT_WIDTH);
    localparam int IDX_W = (MAX > 2) ? $clog2(MAX) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX - 1);

    // Reject width pairings that do not split into at least two slices.
    if (MAX < 2) begin : g_bad_ratio
        $error("shrink_queue: IN_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2");
    end

    state_t               state, state_nxt;
    logic [IN_WIDTH-1:0]  hold, hold_nxt;
    logic [IDX_W-1:0]     idx, idx_nxt;
    logic                 vld_nxt;
    logic                 up_xfer;
    logic                 dn_xfer;
    logic                 last_slice;

    assign last_slice = (idx == LAST_IDX);
    assign up_xfer    = vld_in && rdy_upward;
    assign dn_xfer    = vld_out && rdy_downward;
    assign dout       = hold[OUT_WIDTH-1:0];

    // Upstream readiness depends only on state, slice index and downstream
    // readiness, never on vld_in.
    always_comb begin
        rdy_upward = 1'b0;
        case (state)
            IDLE:    rdy_upward = 1'b1;
            DRAIN:   rdy_upward = last_slice && rdy_downward;
            default: rdy_upward = 1'b0;
        endcase
    end

    // Next-state logic: load, shift out one slice, reload or return to idle.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt = state;
        hold_nxt  = hold;
        idx_nxt   = idx;
        vld_nxt   = vld_out;
        case (state)
            IDLE: begin
                if (up_xfer) begin
                    hold_nxt  = din;
                    idx_nxt   = '0;
                    vld_nxt   = 1'b1;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (dn_xfer) begin
                    if (!last_slice) begin
                        hold_nxt = hold >> OUT_WIDTH;
                        idx_nxt  = idx + IDX_W'(1);
                    end else if (up_xfer) begin
                        // Last slice leaves while the next word arrives:
                        // reload in place so dout never bubbles.
                        hold_nxt = din;
                        idx_nxt  = '0;
                        vld_nxt  = 1'b1;
                    end else begin
                        hold_nxt  = '0;
                        idx_nxt   = '0;
                        vld_nxt   = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                hold_nxt  = '0;
                idx_nxt   = '0;
                vld_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State, shift register, slice index and output-valid registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the data register is reset too, because dout is driven
            // straight from it and must read zero while nothing is valid.
            state   <= IDLE;
            hold    <= '0;
            idx     <= '0;
            vld_out <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values computed before this edge.
            state   <= state_nxt;
            hold    <= hold_nxt;
            idx     <= idx_nxt;
            vld_out <= vld_nxt;
        end
    end

endmodule

// File: tb/tb_shrink_queue.sv
// Self-checking bench for shrink_queue: directed 64->32 scenarios plus a
// randomized 128->32 run, all compared against a slice-queue reference.
module tb_shrink_queue;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Ratio-2 instance
    logic [63:0]  din_a;
    logic         vld_in_a, rdy_up_a, vld_out_a, rdy_dn_a;
    logic [31:0]  dout_a;

    // Ratio-4 instance
    logic [127:0] din_b;
    logic         vld_in_b, rdy_up_b, vld_out_b, rdy_dn_b;
    logic [31:0]  dout_b;

    shrink_queue #(.IN_WIDTH(64), .OUT_WIDTH(32)) dut_a (
        .clk(clk), .reset(reset), .din(din_a), .vld_in(vld_in_a),
        .rdy_upward(rdy_up_a), .dout(dout_a), .vld_out(vld_out_a),
        .rdy_downward(rdy_dn_a)
    );

    shrink_queue #(.IN_WIDTH(128), .OUT_WIDTH(32)) dut_b (
        .clk(clk), .reset(reset), .din(din_b), .vld_in(vld_in_b),
        .rdy_upward(rdy_up_b), .dout(dout_b), .vld_out(vld_out_b),
        .rdy_downward(rdy_dn_b)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference: queue of narrow slices still owed downstream.
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] obs_a[$];
    int          obs_c[$];
    logic        acc_a, acc_b;
    int          pop_b = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock for the ratio-2 instance: compare, predict the edge, advance.
    task automatic tick_a();
        logic        exp_rdy, dn, up;
        logic [31:0] exp_d;
        #1;
        exp_rdy = (qa.size() == 0) || (qa.size() == 1 && rdy_dn_a);
        exp_d   = (qa.size() != 0) ? qa[0] : 32'h0;
        check("a_vld_out", vld_out_a, qa.size() != 0);
        check("a_dout", dout_a, exp_d);
        if (!reset) check("a_rdy_upward", rdy_up_a, exp_rdy);
        dn = (qa.size() != 0) && rdy_dn_a;
        up = vld_in_a && exp_rdy && !reset;
        if (reset) begin
            qa.delete();
        end else begin
            if (dn) begin
                obs_a.push_back(dout_a);
                obs_c.push_back(cyc);
                void'(qa.pop_front());
            end
            if (up) for (int i = 0; i < 2; i++) qa.push_back(din_a[i*32 +: 32]);
        end
        acc_a = up;
        cyc++;
        @(negedge clk);
    endtask

    // One clock for the ratio-4 instance.
    task automatic tick_b();
        logic        exp_rdy, dn, up;
        logic [31:0] exp_d;
        #1;
        exp_rdy = (qb.size() == 0) || (qb.size() == 1 && rdy_dn_b);
        exp_d   = (qb.size() != 0) ? qb[0] : 32'h0;
        check("b_vld_out", vld_out_b, qb.size() != 0);
        check("b_dout", dout_b, exp_d);
        if (!reset) check("b_rdy_upward", rdy_up_b, exp_rdy);
        dn = (qb.size() != 0) && rdy_dn_b;
        up = vld_in_b && exp_rdy && !reset;
        if (reset) begin
            qb.delete();
        end else begin
            if (dn) begin
                pop_b++;
                void'(qb.pop_front());
            end
            if (up) for (int i = 0; i < 4; i++) qb.push_back(din_b[i*32 +: 32]);
        end
        acc_b = up;
        cyc++;
        @(negedge clk);
    endtask

    // Present one wide word to instance A and hold it until accepted.
    task automatic send_a(input logic [63:0] w);
        din_a    = w;
        vld_in_a = 1'b1;
        acc_a    = 1'b0;
        for (int g = 0; g < 50 && !acc_a; g++) tick_a();
        if (!acc_a) check("a_accept_timeout", 1'b0, 1'b1);
        vld_in_a = 1'b0;
    endtask

    task automatic drain_a();
        rdy_dn_a = 1'b1;
        for (int g = 0; g < 50 && qa.size() != 0; g++) tick_a();
        if (qa.size() != 0) check("a_drain_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        din_a = '0; vld_in_a = 1'b0; rdy_dn_a = 1'b1;
        din_b = '0; vld_in_b = 1'b0; rdy_dn_b = 1'b1;
        reset = 1'b1;
        @(negedge clk);

        // Reset held 3 cycles with a word offered: nothing may be taken.
        din_a = 64'hDEAD_BEEF_0BAD_F00D;
        vld_in_a = 1'b1;
        repeat (3) tick_a();
        check("reset_vld_out", vld_out_a, 1'b0);
        check("reset_dout", dout_a, 32'h0);
        vld_in_a = 1'b0;
        reset = 1'b0;
        tick_a();
        check("post_reset_rdy", rdy_up_a, 1'b1);

        // Single word, downstream always ready.
        rdy_dn_a = 1'b1;
        send_a(64'hAAAA_BBBB_CCCC_DDDD);
        check("single_slice0", dout_a, 32'hCCCC_DDDD);
        check("single_vld0", vld_out_a, 1'b1);
        tick_a();
        check("single_slice1", dout_a, 32'hAAAA_BBBB);
        check("single_rdy_last", rdy_up_a, 1'b1);
        tick_a();
        check("single_vld_end", vld_out_a, 1'b0);
        check("single_rdy_idle", rdy_up_a, 1'b1);

        // Back-to-back words: four slices on four consecutive cycles.
        obs_a.delete(); obs_c.delete();
        send_a(64'h1_0000_0002);
        send_a(64'h3_0000_0004);
        drain_a();
        check("b2b_count", obs_a.size(), 4);
        if (obs_a.size() == 4) begin
            check("b2b_s0", obs_a[0], 32'h2);
            check("b2b_s1", obs_a[1], 32'h1);
            check("b2b_s2", obs_a[2], 32'h4);
            check("b2b_s3", obs_a[3], 32'h3);
            check("b2b_no_bubble", obs_c[3] - obs_c[0], 3);
        end

        // Backpressure on the first slice for 5 cycles.
        send_a(64'hAAAA_BBBB_CCCC_DDDD);
        rdy_dn_a = 1'b0;
        repeat (5) tick_a();
        check("bp_dout_held", dout_a, 32'hCCCC_DDDD);
        check("bp_vld_held", vld_out_a, 1'b1);
        check("bp_rdy_low", rdy_up_a, 1'b0);
        obs_a.delete(); obs_c.delete();
        drain_a();
        check("bp_resume_count", obs_a.size(), 2);
        if (obs_a.size() == 2) begin
            check("bp_resume_s0", obs_a[0], 32'hCCCC_DDDD);
            check("bp_resume_s1", obs_a[1], 32'hAAAA_BBBB);
        end

        // Reset after the first slice leaves: the second slice is discarded.
        send_a(64'hAAAA_BBBB_CCCC_DDDD);
        tick_a();
        reset = 1'b1;
        tick_a();
        reset = 1'b0;
        check("mid_reset_vld", vld_out_a, 1'b0);
        check("mid_reset_dout", dout_a, 32'h0);
        obs_a.delete(); obs_c.delete();
        send_a(64'h5_0000_0006);
        drain_a();
        check("mid_reset_count", obs_a.size(), 2);
        if (obs_a.size() == 2) begin
            check("mid_reset_s0", obs_a[0], 32'h6);
            check("mid_reset_s1", obs_a[1], 32'h5);
        end

        // Ratio 4: 1000 random words with random gaps on both sides.
        sent = 0;
        for (int c = 0; c < 20000 && sent < 1000; c++) begin
            if (!vld_in_b && $urandom_range(0, 3) != 0) begin
                din_b    = {$urandom, $urandom, $urandom, $urandom};
                vld_in_b = 1'b1;
            end
            rdy_dn_b = ($urandom_range(0, 4) != 0);
            tick_b();
            if (acc_b) begin
                sent++;
                vld_in_b = 1'b0;
            end
        end
        vld_in_b = 1'b0;
        check("rand_words_sent", sent, 1000);
        rdy_dn_b = 1'b1;
        for (int g = 0; g < 100 && qb.size() != 0; g++) tick_b();
        check("rand_drained", qb.size(), 0);
        check("rand_slices", pop_b, 4000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
